jtag_dr_receiver: RTL and testbench
===================================

// Module: jtag_dr_receiver
// PURPOSE
// Receives user-DR scans from the ECP5 JTAGG primitive (ER1 = IR 0x32, ER2 = IR 0x38).
// - Oversamples JTCK and its companion signals in the system clock domain.
// - Shifts a DR_WIDTH data register LSB-first.
// - On JUPDATE, hands the completed word to the SoC debug register port through a one-entry valid/ready holding register.
// - Replaces the ad-hoc DR logic in the FPGA top; sits between JTAGG and soc.dbgreg_*.
// PARAMETERS
// DR_WIDTH     32  data register width in bits (>=8)
// SYNC_STAGES  2   synchroniser depth for all JTAGG inputs (>=2)
// PORTS
// clk          in   1         system clock (clk48m in top); >=4x JTCK frequency
// rst          in   1         synchronous, active-high reset
// jtck         in   1         JTAGG JTCK (asynchronous to clk)
// jtdi         in   1         JTAGG JTDI
// jshift       in   1         JTAGG JSHIFT
// jupdate      in   1         JTAGG JUPDATE
// jrstn        in   1         JTAGG JRSTN, active-low TAP reset
// jce1         in   1         JTAGG JCE1 (ER1 selected)
// jce2         in   1         JTAGG JCE2 (ER2 selected)
// dr_data      out  DR_WIDTH  last completed DR word
// dr_sel       out  1         0 = ER1, 1 = ER2 for dr_data
// dr_bits      out  6         number of bits shifted for dr_data (saturates at 63)
// dr_valid     out  1         dr_data/dr_sel/dr_bits are valid
// dr_ready     in   1         consumer accepts word when dr_valid & dr_ready
// overrun      out  1         sticky: a word was overwritten before it was accepted
// overrun_clr  in   1         clears overrun
// BEHAVIOUR
// - Reset values: all outputs 0; FSM IDLE; shift reg, bit count, shift_q all 0.
// - Synchronisation: every JTAGG input passes through its own SYNC_STAGES-deep flop chain.
//   - Define tck_s as the last flop of the jtck chain and tck_p as tck_s delayed by 1 clk.
//   - Event: ev = tck_s & ~tck_p, i.e. a rising JTCK edge. All companion signals are read from their chain outputs in the ev cycle.
// - shift_q: register loaded with jshift_s on each ev. A bit is shifted on ev only if shift_q = 1, i.e. JSHIFT was high at the previous rising edge.
//   - Shift: sr <= {jtdi_s, sr[DR_WIDTH-1:1]}.
//   - Bit count: cnt <= sat63(cnt + 1).
// - FSM, evaluated only in ev cycles:
//   - IDLE -> SEL on (jce1_s | jce2_s). Latch sel = jce2_s and clear cnt in the same step.
//   - SEL -> SHIFT when shift_q = 1. Also remains in SEL; jce re-latches sel.
//   - SHIFT -> DONE on jupdate_s. Any state with jupdate_s and no SEL ever reached: ignore, stay IDLE.
//   - DONE performs the hand-off and returns to IDLE on the next ev. In the DONE entry cycle, load dr_data <= sr, dr_sel <= sel, dr_bits <= cnt, dr_valid <= 1.
// - Latency: JTCK rising edge carrying JUPDATE -> dr_valid high after SYNC_STAGES + 2 clk.
// - Short scans (cnt < DR_WIDTH): the word is delivered unpadded (bits right-aligned toward MSB), and dr_bits reports cnt.
// - Long scans: the oldest bits fall off the LSB.
// - Handshake:
//   - dr_valid stays high until dr_valid & dr_ready; it drops the next clk.
//   - Hand-off and acceptance in the same clk: new word loaded, dr_valid stays 1, no overrun.
//   - Hand-off while dr_valid & ~dr_ready: word overwritten and overrun <= 1.
//   - overrun_clr and a new overrun in the same clk: overrun stays 1 (set wins).
// - TAP reset: jrstn_s = 0 forces FSM IDLE and clears sr, cnt, shift_q.
//   - The holding register (dr_*), dr_valid and overrun are NOT affected.
//   - Mid-scan TAP reset discards the partial word.
// - rst mid-scan: everything cleared. The next hand-off requires a fresh jce selection.
// CONFIGURATION
// - JTAG_DR_TDO_EN defined:
//   - Adds ports: dr_capture (in, DR_WIDTH), jtdo1 (out, 1), jtdo2 (out, 1).
//   - On the IDLE -> SEL ev: tx <= dr_capture.
//   - On each shifting ev: tx <= {1'b0, tx[DR_WIDTH-1:1]}.
//   - Outputs: jtdo1 = tx[0] & ~sel; jtdo2 = tx[0] & sel. Both reset to 0.
// - JTAG_DR_TDO_EN undefined: ports and tx register absent; the DR is write-only from the host.
// TESTING
// - rst high 3 clk -> all outputs 0; then 100 clk with jtck idle -> dr_valid stays 0.
// - ER1 scan of 32 bits 0xDEADBEEF LSB-first, then JUPDATE (JTCK = clk/8) -> dr_data = 0xDEADBEEF, dr_sel = 0, dr_bits = 32, dr_valid rises SYNC_STAGES + 2 clk after the update edge.
// - ER2 scan of 8 bits 0xA5 -> dr_data[31:24] = 0xA5, dr_sel = 1, dr_bits = 8.
// - Two scans with dr_ready = 0 -> second word held, overrun = 1; overrun_clr -> overrun = 0; dr_ready pulse -> dr_valid falls next clk.
// - jrstn low after 10 shifted bits, then full 0x12345678 scan -> only 0x12345678 delivered, dr_bits = 32.
// - JTAG_DR_TDO_EN with dr_capture = 0x0000_00F1 on ER1 -> jtdo1 sequence 1,0,0,0,1,1,1,1,0... with jtdo2 held at 0.

Source files
------------

// File: rtl/jtag_dr_receiver_if.sv
// jtag_dr_receiver_if
//   Hand-off port between the JTAG user-DR receiver and the SoC debug
//   register consumer. One word plus its attributes, valid/ready qualified.
//   dr_data   last completed DR word
//   dr_sel    0 = ER1, 1 = ER2
//   dr_bits   number of bits shifted for dr_data (saturates at 63)
//   dr_valid  word/attributes valid
//   dr_ready  consumer accepts the word when dr_valid & dr_ready
//   master = receiver side, slave = consumer side.
interface jtag_dr_receiver_if #(
  parameter int unsigned DR_WIDTH = 32
);
  logic [DR_WIDTH-1:0] dr_data;
  logic                dr_sel;
  logic [5:0]          dr_bits;
  logic                dr_valid;
  logic                dr_ready;

  modport master (
    output dr_data,
    output dr_sel,
    output dr_bits,
    output dr_valid,
    input  dr_ready
  );

  modport slave (
    input  dr_data,
    input  dr_sel,
    input  dr_bits,
    input  dr_valid,
    output dr_ready
  );
endinterface

// File: rtl/jtag_dr_receiver.sv
// jtag_dr_receiver
//   Receives user-DR scans (ER1/ER2) from the ECP5 JTAGG primitive by
//   oversampling JTCK and its companion signals in the clk domain, shifts a
//   DR_WIDTH register LSB-first and, on JUPDATE, hands the finished word to
//   the debug register port through a one-entry valid/ready holding register.
// Ports
//   clk, rst        system clock (>= 4x JTCK), synchronous active-high reset
//   jtck..jce2      raw JTAGG outputs, asynchronous to clk
//   dr              hand-off port (jtag_dr_receiver_if.master)
//   overrun         sticky: an unaccepted word was overwritten
//   overrun_clr     clears overrun (a simultaneous new overrun wins)
// Optional feature (macro JTAG_DR_TDO_EN)
//   dr_capture      word loaded into the readback register on selection
//   jtdo1, jtdo2    readback data toward JTAGG for ER1 / ER2
module jtag_dr_receiver #(
  parameter int unsigned DR_WIDTH    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jtck,
  input  logic                jtdi,
  input  logic                jshift,
  input  logic                jupdate,
  input  logic                jrstn,
  input  logic                jce1,
  input  logic                jce2,
  jtag_dr_receiver_if.master  dr,
  output logic                overrun,
  input  logic                overrun_clr
`ifdef JTAG_DR_TDO_EN
  ,
  input  logic [DR_WIDTH-1:0] dr_capture,
  output logic                jtdo1,
  output logic                jtdo2
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One independent flop chain per JTAGG input, packed side by side.
  localparam int unsigned NSIG = 7;

  logic [NSIG-1:0]                  in_vec;
  logic [SYNC_STAGES-1:0][NSIG-1:0] sync;
  logic [NSIG-1:0]                  sync_out;

  logic tck_s, tdi_s, shift_s, update_s, rstn_s, ce1_s, ce2_s;
  logic tck_p;
  logic ev;

  state_t              state;
  logic [DR_WIDTH-1:0] sr;
  logic [5:0]          cnt;
  logic                shift_q;
  logic                sel;
  logic                done_first;
`ifdef JTAG_DR_TDO_EN
  logic [DR_WIDTH-1:0] tx;
`endif

  assign in_vec   = {jrstn, jce2, jce1, jupdate, jshift, jtdi, jtck};
  assign sync_out = sync[SYNC_STAGES-1];
  assign {rstn_s, ce2_s, ce1_s, update_s, shift_s, tdi_s, tck_s} = sync_out;

  assign ev = tck_s & ~tck_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_vec};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_p       <= 1'b0;
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      shift_q     <= 1'b0;
      sel         <= 1'b0;
      done_first  <= 1'b0;
      dr.dr_data  <= '0;
      dr.dr_sel   <= 1'b0;
      dr.dr_bits  <= '0;
      dr.dr_valid <= 1'b0;
      overrun     <= 1'b0;
`ifdef JTAG_DR_TDO_EN
      tx          <= '0;
`endif
    end else begin
      tck_p      <= tck_s;
      done_first <= 1'b0;

      if (!rstn_s) begin
        state   <= IDLE;
        sr      <= '0;
        cnt     <= '0;
        shift_q <= 1'b0;
      end else if (ev) begin
        shift_q <= shift_s;
        // shift_q still holds JSHIFT from the previous rising edge here.
        if (shift_q) begin
          sr  <= {tdi_s, sr[DR_WIDTH-1:1]};
          cnt <= (cnt == 6'd63) ? cnt : cnt + 6'd1;
`ifdef JTAG_DR_TDO_EN
          tx  <= {1'b0, tx[DR_WIDTH-1:1]};
`endif
        end
        unique case (state)
          IDLE: begin
            if (ce1_s | ce2_s) begin
              state <= SEL;
              sel   <= ce2_s;
              cnt   <= '0;
`ifdef JTAG_DR_TDO_EN
              tx    <= dr_capture;
`endif
            end
          end
          SEL: begin
            if (ce1_s | ce2_s) sel <= ce2_s;
            if (shift_q) state <= SHIFT;
          end
          SHIFT: begin
            if (update_s) begin
              state      <= DONE;
              done_first <= 1'b1;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // Hand-off lands one clk after DONE is entered; a same-clk acceptance
      // is absorbed by the reload, so dr_valid stays high.
      if (done_first) begin
        dr.dr_data  <= sr;
        dr.dr_sel   <= sel;
        dr.dr_bits  <= cnt;
        dr.dr_valid <= 1'b1;
        if (dr.dr_valid && !dr.dr_ready) begin
          overrun <= 1'b1;
        end else if (overrun_clr) begin
          overrun <= 1'b0;
        end
      end else begin
        if (dr.dr_valid && dr.dr_ready) dr.dr_valid <= 1'b0;
        if (overrun_clr) overrun <= 1'b0;
      end
    end
  end

`ifdef JTAG_DR_TDO_EN
  assign jtdo1 = tx[0] & ~sel;
  assign jtdo2 = tx[0] & sel;
`endif

endmodule

// File: tb/tb_jtag_dr_receiver.sv
module tb_jtag_dr_receiver;
  logic clk = 1'b0;
  logic rst, jtck, jtdi, jshift, jupdate, jrstn, jce1, jce2;
  logic overrun, overrun_clr;
`ifdef JTAG_DR_TDO_EN
  logic [31:0] dr_capture;
  logic        jtdo1, jtdo2;
`endif

  int nvec = 0;
  int nerr = 0;

  jtag_dr_receiver_if #(.DR_WIDTH(32)) dr_if ();

  jtag_dr_receiver #(.DR_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .jtck        (jtck),
    .jtdi        (jtdi),
    .jshift      (jshift),
    .jupdate     (jupdate),
    .jrstn       (jrstn),
    .jce1        (jce1),
    .jce2        (jce2),
    .dr          (dr_if),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`ifdef JTAG_DR_TDO_EN
    ,
    .dr_capture  (dr_capture),
    .jtdo1       (jtdo1),
    .jtdo2       (jtdo2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One JTCK period = 8 clk; companions settle 2 clk before the rising edge.
  task automatic tck_cycle(input logic tdi, input logic sh, input logic c1,
                           input logic c2, input logic up);
    jtdi = tdi; jshift = sh; jce1 = c1; jce2 = c2; jupdate = up;
    clk_wait(2);
    jtck = 1'b1;
    clk_wait(4);
    jtck = 1'b0;
    clk_wait(2);
  endtask

  // Update cycle; lat = clk count from JTCK rise to dr_valid seen high.
  task automatic do_update(input int rdy_at, output int lat);
    bit seen = 0;
    lat = -1;
    jtdi = 1'b0; jshift = 1'b0; jce1 = 1'b0; jce2 = 1'b0; jupdate = 1'b1;
    clk_wait(2);
    jtck = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      clk_wait(1);
      if (i == rdy_at) dr_if.dr_ready = 1'b1;
      if (i == rdy_at + 1) dr_if.dr_ready = 1'b0;
      if (!seen && dr_if.dr_valid) begin
        seen = 1;
        lat  = i;
      end
      if (i == 4) jtck = 1'b0;
    end
    jupdate = 1'b0;
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_scan(input logic er2, input logic [127:0] v, input int n,
                         input int rdy_at, output int lat);
    tck_cycle(1'b0, 1'b0, ~er2, er2, 1'b0);
    tck_cycle(1'b0, 1'b1, ~er2, er2, 1'b0);
    for (int i = 0; i < n; i++)
      tck_cycle(v[i], (i < n - 1), ~er2, er2, 1'b0);
    do_update(rdy_at, lat);
  endtask

  task automatic consume();
    dr_if.dr_ready = 1'b1;
    clk_wait(1);
    dr_if.dr_ready = 1'b0;
    chk("valid_drop", {63'd0, dr_if.dr_valid}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [127:0] v;
    rst = 1'b1; jtck = 1'b0; jtdi = 1'b0; jshift = 1'b0; jupdate = 1'b0;
    jrstn = 1'b1; jce1 = 1'b0; jce2 = 1'b0; overrun_clr = 1'b0;
    dr_if.dr_ready = 1'b0;
`ifdef JTAG_DR_TDO_EN
    dr_capture = 32'h0;
`endif
    clk_wait(3);
    chk("rst_data",    {32'd0, dr_if.dr_data}, 64'd0);
    chk("rst_sel",     {63'd0, dr_if.dr_sel}, 64'd0);
    chk("rst_bits",    {58'd0, dr_if.dr_bits}, 64'd0);
    chk("rst_valid",   {63'd0, dr_if.dr_valid}, 64'd0);
    chk("rst_overrun", {63'd0, overrun}, 64'd0);
`ifdef JTAG_DR_TDO_EN
    chk("rst_jtdo", {62'd0, jtdo1, jtdo2}, 64'd0);
`endif
    rst = 1'b0;
    clk_wait(100);
    chk("idle_valid", {63'd0, dr_if.dr_valid}, 64'd0);

    // ER1, 32 bits
    v = {96'd0, 32'hDEADBEEF};
    do_scan(1'b0, v, 32, 0, lat);
    chk("er1_latency", lat, 64'd4);
    chk("er1_data",    {32'd0, dr_if.dr_data}, 64'hDEADBEEF);
    chk("er1_sel",     {63'd0, dr_if.dr_sel}, 64'd0);
    chk("er1_bits",    {58'd0, dr_if.dr_bits}, 64'd32);
    chk("er1_valid",   {63'd0, dr_if.dr_valid}, 64'd1);
    consume();

    // ER2, short 8-bit scan lands in the top byte
    v = {120'd0, 8'hA5};
    do_scan(1'b1, v, 8, 0, lat);
    chk("er2_top",  {56'd0, dr_if.dr_data[31:24]}, 64'hA5);
    chk("er2_sel",  {63'd0, dr_if.dr_sel}, 64'd1);
    chk("er2_bits", {58'd0, dr_if.dr_bits}, 64'd8);
    consume();

    // JUPDATE with no selection is ignored
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nosel_valid", {63'd0, dr_if.dr_valid}, 64'd0);

    // Overrun: two words without acceptance
    v = {96'd0, 32'h11111111};
    do_scan(1'b0, v, 32, 0, lat);
    v = {96'd0, 32'h2222_3333};
    do_scan(1'b1, v, 32, 0, lat);
    chk("ovr_data", {32'd0, dr_if.dr_data}, 64'h2222_3333);
    chk("ovr_sel",  {63'd0, dr_if.dr_sel}, 64'd1);
    chk("ovr_set",  {63'd0, overrun}, 64'd1);
    overrun_clr = 1'b1;
    clk_wait(1);
    overrun_clr = 1'b0;
    chk("ovr_clr",   {63'd0, overrun}, 64'd0);
    chk("ovr_valid", {63'd0, dr_if.dr_valid}, 64'd1);
    consume();

    // Hand-off and acceptance in the same clk
    v = {96'd0, 32'hCAFEF00D};
    do_scan(1'b0, v, 32, 0, lat);
    v = {96'd0, 32'h0BADC0DE};
    do_scan(1'b0, v, 32, 3, lat);
    chk("same_valid",   {63'd0, dr_if.dr_valid}, 64'd1);
    chk("same_data",    {32'd0, dr_if.dr_data}, 64'h0BADC0DE);
    chk("same_overrun", {63'd0, overrun}, 64'd0);
    consume();

    // Long scan: oldest bits drop, count saturates
    v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    do_scan(1'b0, v, 70, 0, lat);
    chk("long_data", {32'd0, dr_if.dr_data}, {32'd0, v[38 +: 32]});
    chk("long_bits", {58'd0, dr_if.dr_bits}, 64'd63);
    consume();

    // TAP reset mid-scan discards the partial word
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    jshift = 1'b0; jce1 = 1'b0;
    jrstn = 1'b0;
    clk_wait(6);
    jrstn = 1'b1;
    clk_wait(4);
    chk("tap_valid", {63'd0, dr_if.dr_valid}, 64'd0);
    v = {96'd0, 32'h12345678};
    do_scan(1'b0, v, 32, 0, lat);
    chk("tap_data", {32'd0, dr_if.dr_data}, 64'h12345678);
    chk("tap_bits", {58'd0, dr_if.dr_bits}, 64'd32);
    consume();

`ifdef JTAG_DR_TDO_EN
    begin
      logic [7:0] seq;
      seq = 8'b0111_1000;  // jtdo1 after shifts 1..8, bit 0 first
      dr_capture = 32'h0000_00F1;
      tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("tdo_load", {62'd0, jtdo1, jtdo2}, 64'd2);
      tck_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        tck_cycle(1'b0, (i < 7), 1'b1, 1'b0, 1'b0);
        chk("tdo_seq", {62'd0, jtdo1, jtdo2}, {62'd0, seq[i], 1'b0});
      end
      do_update(0, lat);
      chk("tdo_valid", {63'd0, dr_if.dr_valid}, 64'd1);
      consume();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
